control_fsm: RTL

- Multi-cycle sequencer for the 16-bit CPU datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives all datapath write enables, including the NZP flag register write enable (nzp_we).
- Resolves conditional branches from the current N/Z/P flags.
- Sits between the instruction register and the datapath. It handshakes with the memory port using req/ready and has a stall watchdog.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/mem_watchdog.sv | 29 ++
 rtl/control_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes,
// sequencer states and the datapath mux select encodings.
package cpu_pkg;

  // Instruction opcodes (ir[15:12])
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // Sequencer states
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // PC source select
  localparam logic [1:0] PC_SEL_INC   = 2'd0;
  localparam logic [1:0] PC_SEL_OFF9  = 2'd1;
  localparam logic [1:0] PC_SEL_BASER = 2'd2;

  // Register-file write source select
  localparam logic [1:0] RF_SRC_ALU   = 2'd0;
  localparam logic [1:0] RF_SRC_MDR   = 2'd1;
  localparam logic [1:0] RF_SRC_PCOFF = 2'd2;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_NOT = 2'd2;

  // True for the opcodes that write memory during MEM
  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory stall watchdog: counts cycles a request goes unacknowledged and
// flags a timeout once the count has reached WAIT_MAX with still no ready.
module mem_watchdog #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CW       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  logic [CW-1:0] count;

  // Wait counter: cleared on phase entry or on acknowledge, else counts stalls
  always_ff @(posedge clk) begin
    if (reset || start || (req && ready)) begin
      count <= '0;
    end else if (req) begin
      count <= count + CW'(1);
    end
  end

  // A ready in the same cycle the limit is reached takes precedence
  assign timeout = req && !ready && (count == CW'(WAIT_MAX));

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// driving datapath write enables and mux selects, with a memory watchdog.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CW       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        n_flag,
  input  logic        z_flag,
  input  logic        p_flag,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        mar_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        nzp_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  rf_src,
  output logic [1:0]  alu_op,
  output logic        branch_taken,
  output logic        halted,
  output logic        bus_err
);

  state_t     state, state_next;
  logic       halted_q, bus_err_q;
  logic       halted_set, bus_err_set;
  logic       wd_start, wd_timeout;
  logic [3:0] opcode;
  logic       taken;
  logic       unused_ir;

  assign opcode    = ir[15:12];
  assign taken     = |(ir[11:9] & {n_flag, z_flag, p_flag});
  assign unused_ir = ^ir[8:0];

  // Request is purely state-decoded so the watchdog timeout has no loop back
  assign mem_req  = !reset && ((state == S_FETCH) || (state == S_MEM));
  assign halted   = !reset && halted_q;
  assign bus_err  = !reset && bus_err_q;

  // The counter restarts whenever a memory phase is freshly entered
  assign wd_start = (state_next != state) &&
                    ((state_next == S_FETCH) || (state_next == S_MEM));

  mem_watchdog #(
    .WAIT_MAX (WAIT_MAX),
    .CW       (CW)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (wd_start),
    .req     (mem_req),
    .ready   (mem_ready),
    .timeout (wd_timeout)
  );

  // Next-state and output decode from state, ir and mem_ready
  always_comb begin
    state_next   = state;
    halted_set   = 1'b0;
    bus_err_set  = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_we        = 1'b0;
    mar_we       = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    nzp_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_INC;
    rf_src       = RF_SRC_ALU;
    alu_op       = ALU_ADD;
    branch_taken = 1'b0;

    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          pc_sel     = PC_SEL_INC;
          state_next = S_DECODE;
        end else if (wd_timeout) begin
          state_next  = S_HALT;
          halted_set  = 1'b1;
          bus_err_set = 1'b1;
        end
      end

      S_DECODE: state_next = S_EXEC;

      S_EXEC: begin
        state_next = S_FETCH;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_we  = 1'b1;
            nzp_we = 1'b1;
            rf_src = RF_SRC_ALU;
            alu_op = (opcode == OP_ADD) ? ALU_ADD :
                     (opcode == OP_AND) ? ALU_AND : ALU_NOT;
          end
          OP_LEA: begin
            rf_we  = 1'b1;
            rf_src = RF_SRC_PCOFF;
          end
          OP_BR: begin
            if (taken) begin
              branch_taken = 1'b1;
              pc_we        = 1'b1;
              pc_sel       = PC_SEL_OFF9;
            end
          end
          OP_JMP: begin
            pc_we  = 1'b1;
            pc_sel = PC_SEL_BASER;
          end
          OP_LD, OP_LDR, OP_ST, OP_STR: begin
            mar_we     = 1'b1;
            state_next = S_MEM;
          end
          default: begin
            state_next = S_HALT;
            halted_set = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        addr_sel = 1'b1;
        mem_we   = is_store(opcode);
        if (mem_ready) begin
          if (is_store(opcode)) begin
            state_next = S_FETCH;
          end else begin
            mdr_we     = 1'b1;
            state_next = S_WB;
          end
        end else if (wd_timeout) begin
          state_next  = S_HALT;
          halted_set  = 1'b1;
          bus_err_set = 1'b1;
        end
      end

      S_WB: begin
        rf_we      = 1'b1;
        rf_src     = RF_SRC_MDR;
        nzp_we     = 1'b1;
        state_next = S_FETCH;
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_FETCH;
    endcase

    // Reset silences every output, so an interrupted access pulses nothing
    if (reset) begin
      mem_we       = 1'b0;
      addr_sel     = 1'b0;
      ir_we        = 1'b0;
      mar_we       = 1'b0;
      mdr_we       = 1'b0;
      rf_we        = 1'b0;
      nzp_we       = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = '0;
      rf_src       = '0;
      alu_op       = '0;
      branch_taken = 1'b0;
    end
  end

  // State register plus sticky halt / bus-error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (halted_set)  halted_q  <= 1'b1;
      if (bus_err_set) bus_err_q <= 1'b1;
    end
  end

endmodule
